// File: rtl/gpio_bus_bridge.sv
// CPU valid/ready front-end for the GPIO register bank.
// Keeps a shadow of every device register and parks the device on a no-change rewrite when idle.
module gpio_bus_bridge #(
  parameter int unsigned NUM_GPIO_SETS = 4,
  parameter int unsigned GPIO_WIDTH    = 8,
  localparam int unsigned ADDR_W       = $clog2(NUM_GPIO_SETS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [GPIO_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [GPIO_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  gpio_rst_o,
  output logic [ADDR_W-1:0]     gpio_addr_o,
  output logic [GPIO_WIDTH-1:0] gpio_wr_data_o,
  input  logic [GPIO_WIDTH-1:0] gpio_rd_data_i
);

  localparam int unsigned NUM_REGS = 2 * NUM_GPIO_SETS;

  typedef enum logic [2:0] {
    S_SWEEP,
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic                    gpio_rst_q, gpio_rst_d;
  logic [ADDR_W-1:0]       gpio_addr_q, gpio_addr_d;
  logic [GPIO_WIDTH-1:0]   gpio_wr_data_q, gpio_wr_data_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [GPIO_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [GPIO_WIDTH-1:0]   wdata_q, wdata_d;
  logic [GPIO_WIDTH-1:0]   shd_q [NUM_REGS];
  logic [GPIO_WIDTH-1:0]   shd_d [NUM_REGS];
  logic                    park;
  logic                    addr_bad;
  logic [ADDR_W-1:0]       dir_addr;

  // Compare one bit wider so a full power-of-two register map never aliases to zero
  assign addr_bad = {1'b0, req_addr_i} >= (ADDR_W + 1)'(NUM_REGS);
  assign dir_addr = addr_q ^ ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_SWEEP;
      cnt_q          <= '0;
      gpio_rst_q     <= 1'b1;
      gpio_addr_q    <= '0;
      gpio_wr_data_q <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shd_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gpio_rst_q     <= gpio_rst_d;
      gpio_addr_q    <= gpio_addr_d;
      gpio_wr_data_q <= gpio_wr_data_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      shd_q          <= shd_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gpio_rst_d     = 1'b0;
    gpio_addr_d    = ADDR_W'(1);
    gpio_wr_data_d = gpio_wr_data_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    shd_d          = shd_q;
    park           = 1'b1;

    case (state_q)
      S_SWEEP: begin
        park        = 1'b0;
        gpio_rst_d  = 1'b1;
        cnt_d       = cnt_q + ADDR_W'(1);
        gpio_addr_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d     = S_IDLE;
          gpio_rst_d  = 1'b0;
          gpio_addr_d = ADDR_W'(1);
          cnt_d       = '0;
          req_ready_d = 1'b1;
          park        = 1'b1;
        end
      end
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (addr_bad) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else if (!req_we_i && !req_addr_i[0]) begin
            rsp_rdata_d = shd_q[req_addr_i];
            state_d     = S_RESP;
          end else begin
            park           = 1'b0;
            gpio_addr_d    = req_addr_i;
            gpio_wr_data_d = req_we_i ? req_wdata_i : shd_q[req_addr_i];
            state_d        = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Data writes only land on pins whose direction bit selects output
        if (we_q) begin
          if (!addr_q[0]) shd_d[addr_q] = wdata_q;
          else shd_d[addr_q] = (shd_q[dir_addr] & wdata_q) | (~shd_q[dir_addr] & shd_q[addr_q]);
          state_d = S_RESP;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        rsp_rdata_d = gpio_rd_data_i;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_SWEEP;
    endcase

    if (park) gpio_wr_data_d = shd_d[1];
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;
  assign gpio_rst_o     = gpio_rst_q;
  assign gpio_addr_o    = gpio_addr_q;
  assign gpio_wr_data_o = gpio_wr_data_q;

endmodule
